// File: rtl/traffic_pkg.sv
// ============================================================================
// Module : traffic_pkg
// Brief  : Phase state encoding and default count width shared by the timer
//          and the traffic-light FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [0:0] {
        PH_IDLE = 1'b0,
        PH_RUN  = 1'b1
    } phase_state_t;

endpackage

`default_nettype wire

// File: rtl/slow_edge_sync.sv
// ============================================================================
// Module : slow_edge_sync
// Brief  : Synchronises a slow level into clk_in and emits a one-cycle tick
//          per rising edge, suppressed during post-reset warm-up.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module slow_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic din,
    output logic tick
);

    localparam int                WARM_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] C_WARM_LAST = WARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [WARM_W-1:0]      r_warm;
    logic                   w_warm_done;
    logic                   w_edge;

    assign w_warm_done = (r_warm == C_WARM_LAST);
    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Warm-up hides the chain filling with a level that was already high.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_warm <= '0;
            tick   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (!w_warm_done) begin
                r_warm <= r_warm + WARM_W'(1);
            end
            tick <= w_edge & w_warm_done;
        end
    end

endmodule

`default_nettype wire

// File: rtl/slow_tick_phase_timer.sv
// ============================================================================
// Module : slow_tick_phase_timer
// Brief  : Loadable phase down-counter advanced by ticks derived from a slow
//          divided clock sampled as data in the clk_in domain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module slow_tick_phase_timer
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pause,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    phase_state_t r_state;

    slow_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .din    (slow_clk),
        .tick   (tick)
    );

    // A load always wins; a tick coinciding with it is dropped.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= PH_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                remaining <= load_val;
                if (load_val == '0) begin
                    r_state <= PH_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    r_state <= PH_RUN;
                    busy    <= 1'b1;
                end
            end else begin
                case (r_state)
                    PH_RUN: begin
                        if (tick && !pause && remaining != '0) begin
                            if (remaining > CNT_W'(1)) begin
                                remaining <= remaining - CNT_W'(1);
                            end else begin
                                remaining <= '0;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                r_state   <= PH_IDLE;
                            end
                        end
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slow_tick_phase_timer.sv
// ============================================================================
// Module : tb_slow_tick_phase_timer
// Brief  : Directed self-checking bench for slow_tick_phase_timer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_slow_tick_phase_timer;

    logic       clk_in;
    logic       rst;
    logic       slow_clk;
    logic       load;
    logic [7:0] load_val;
    logic       pause;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int vectors;
    int miscompares;
    int tick_count;

    slow_tick_phase_timer #(
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .slow_clk  (slow_clk),
        .load      (load),
        .load_val  (load_val),
        .pause     (pause),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic b, input logic d, input logic [7:0] r);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".remaining"}, 32'(remaining), 32'(r));
    endtask

    // One 16-cycle slow_clk period (8 high, 8 low). The tick is seen after
    // the 3rd edge of the high half and acted on at the 4th.
    task automatic period(input logic p, input logic [7:0] rem_pre, input logic [7:0] rem_post,
                          input logic busy_post, input logic done_post);
        pause    = p;
        slow_clk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("period.tick_hi", 32'(tick), 32'(i == 3));
            if (tick) tick_count++;
            if (i == 3) chk("period.rem_pre", 32'(remaining), 32'(rem_pre));
            if (i == 4) chk_outputs("period.post", busy_post, done_post, rem_post);
            if (i == 5) chk("period.done_clear", 32'(done), 32'(0));
        end
        slow_clk = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("period.tick_lo", 32'(tick), 32'(0));
            if (tick) tick_count++;
        end
        pause = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        tick_count  = 0;
        rst         = 1'b1;
        slow_clk    = 1'b1;
        load        = 1'b0;
        load_val    = 8'd0;
        pause       = 1'b0;

        // Reset with slow_clk held high: no tick after release.
        step();
        step();
        chk("reset.tick", 32'(tick), 32'(0));
        chk_outputs("reset", 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) tick_count++;
        end
        chk("warmup.tick_count", 32'(tick_count), 32'(0));
        chk_outputs("warmup", 1'b0, 1'b0, 8'd0);

        // Tick latency: four idle periods, exactly four ticks.
        slow_clk = 1'b0;
        for (int i = 0; i < 8; i++) step();
        tick_count = 0;
        for (int k = 0; k < 4; k++) period(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("latency.tick_count", 32'(tick_count), 32'(4));

        // Normal phase of 3 ticks.
        load = 1'b1; load_val = 8'd3;
        step();
        load = 1'b0;
        chk_outputs("load3", 1'b1, 1'b0, 8'd3);
        period(1'b0, 8'd3, 8'd2, 1'b1, 1'b0);
        period(1'b0, 8'd2, 8'd1, 1'b1, 1'b0);
        period(1'b0, 8'd1, 8'd0, 1'b0, 1'b1);

        // Pause held across the first tick.
        load = 1'b1; load_val = 8'd2;
        step();
        load = 1'b0;
        chk_outputs("load2", 1'b1, 1'b0, 8'd2);
        period(1'b1, 8'd2, 8'd2, 1'b1, 1'b0);
        period(1'b0, 8'd2, 8'd1, 1'b1, 1'b0);
        period(1'b0, 8'd1, 8'd0, 1'b0, 1'b1);

        // Reload colliding with the final tick.
        load = 1'b1; load_val = 8'd1;
        step();
        load = 1'b0;
        chk_outputs("load1", 1'b1, 1'b0, 8'd1);
        slow_clk = 1'b1;
        step(); step(); step();
        chk("collide.tick", 32'(tick), 32'(1));
        load = 1'b1; load_val = 8'd5;
        step();
        load = 1'b0;
        chk_outputs("collide", 1'b1, 1'b0, 8'd5);
        step();
        chk_outputs("collide.after", 1'b1, 1'b0, 8'd5);
        slow_clk = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Back-to-back loads: the last one wins.
        load = 1'b1; load_val = 8'd7;
        step();
        load_val = 8'd9;
        step();
        load = 1'b0;
        chk_outputs("b2b", 1'b1, 1'b0, 8'd9);

        // Zero-length load from RUN.
        load = 1'b1; load_val = 8'd0;
        step();
        load = 1'b0;
        chk_outputs("zero", 1'b0, 1'b1, 8'd0);
        step();
        chk_outputs("zero.after", 1'b0, 1'b0, 8'd0);

        // Abort with remaining=4.
        load = 1'b1; load_val = 8'd4;
        step();
        load = 1'b0;
        chk_outputs("load4", 1'b1, 1'b0, 8'd4);
        rst = 1'b1;
        #1;
        chk_outputs("abort.async", 1'b0, 1'b0, 8'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outputs("abort.after", 1'b0, 1'b0, 8'd0);
            chk("abort.tick", 32'(tick), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slow_tick_phase_timer.md
# slow_tick_phase_timer

Consumer end of the divided-clock path. Takes the slow square wave from the clock divider as a plain input and samples it in the fast `clk_in` domain. Converts each rising edge into a one-cycle `tick` strobe. Uses those ticks to run a loadable phase down-counter, which the traffic-light FSM uses to time each light phase. The FSM never clocks logic on the divided signal.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `slow_clk`; legal values 2–4.
- `CNT_W`, default 8: width of the phase count, in ticks.
- `clk_in`  in  1  fast system clock; the only clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `slow_clk`  in  1  divided clock, treated as data.
- `load`  in  1  one-cycle request to start or restart a phase.
- `load_val`  in  CNT_W  phase length in ticks; sampled when `load`=1.
- `pause`  in  1  level; while high, ticks do not decrement the count.
- `tick`  out  1  one-cycle strobe per `slow_clk` rising edge.
- `busy`  out  1  high while a phase is counting.
- `done`  out  1  one-cycle strobe when a phase expires.
- `remaining`  out  CNT_W  ticks left in the current phase.

## Operation
- **Synchronizer:** `slow_clk` passes through a chain of `SYNC_STAGES` flops.
- **Edge detector:** a `prev` flop holds the last chain output. `tick` = chain output AND NOT `prev`, registered.
- **Warm-up:** a counter of `SYNC_STAGES`+1 cycles runs after reset release. `tick` is forced low until it completes, so a `slow_clk` that is high at reset release produces no tick.
- **State IDLE:** `busy`=0 and `remaining` holds its last value.
  - `load` with `load_val`≠0 → RUN, `remaining`←`load_val`.
  - `load` with `load_val`=0 → stay IDLE, pulse `done` next cycle, `remaining`←0.
- **State RUN:** `busy`=1.
  - `tick` && !`pause` && `remaining`>1 → `remaining`−1.
  - `tick` && !`pause` && `remaining`=1 → `remaining`←0, `done` pulses, go to IDLE.
- **`load` during RUN:** restarts the phase. `remaining`←`load_val` and the state follows the IDLE rules for that value. Load wins over a coincident tick; that tick is discarded.
- **`pause`:** ticks still appear on `tick` but are ignored by the counter. `pause` has no effect on `load`.
- **Arithmetic:** `remaining` is unsigned and never wraps below 0. Decrement happens only in RUN with `remaining`≥1.
- **Reset mid-phase:** the phase is aborted. No `done` is produced for the aborted phase.

## Timing
- **Reset values:** `tick`=0, `busy`=0, `done`=0, `remaining`=0. State=IDLE, synchronizer and `prev`=0, warm-up counter=0.
- **Tick latency:** `tick` is high exactly one cycle, `SYNC_STAGES`+1 `clk_in` edges after the first edge that samples `slow_clk` high.
- **Load latency:** `load` at edge N → `busy` and `remaining` updated after edge N (visible in cycle N+1).
- **Expiry:** `done` and the return of `busy` to 0 occur in the same cycle, one edge after the final tick. `remaining` reads 0 in that cycle.
- **`slow_clk` constraint:** high and low phases must each be ≥`SYNC_STAGES`+2 `clk_in` cycles. Shorter pulses may be missed; this is not an error condition.
- **Throughput:** at most one decrement per tick. Back-to-back loads are accepted every cycle, and the last one wins.

## Structure
- **Shared package (`traffic_pkg`):** phase state encoding (`PH_IDLE`, `PH_RUN`) and the default `CNT_W`. The traffic FSM uses the same constants for phase lengths.
- **Sub-module `slow_edge_sync`:** the synchronizer chain, `prev` flop, warm-up counter and `tick` generation. Parameterised by `SYNC_STAGES`. Reusable for the pedestrian button input.
- **Top level:** contains only the phase FSM and down-counter.

## Test plan
- **Reset with `slow_clk` high:** assert `rst` with `slow_clk`=1, release it, hold `slow_clk` at 1 for 20 cycles → no `tick`; `busy`=0, `done`=0, `remaining`=0.
- **Tick latency:** toggle `slow_clk` with a period of 16 cycles, `SYNC_STAGES`=2 → `tick` is a single-cycle pulse 3 edges after each rising edge; exactly 4 ticks in 64 cycles.
- **Normal phase:** `load`=1 with `load_val`=3, then run 3 ticks → `remaining` reads 3→2→1→0. `done` and `busy`=0 appear one cycle after the third tick.
- **Pause:** `load_val`=2, hold `pause` across the first tick, then release → `remaining` stays 2 through that tick; `done` pulses after the third tick overall.
- **Reload collision:** in RUN with `remaining`=1, assert `load` with `load_val`=5 in the same cycle as `tick` → `remaining`=5, no `done`, `busy` stays 1.
- **Zero-length load and abort:** `load_val`=0 → `done` pulses one cycle later and `busy` never rises. Assert `rst` mid-phase with `remaining`=4 → outputs return to reset values and no `done` appears.
